// File: rtl/uart_pkg.sv
// Shared UART definitions.
// Holds the transmitter FSM state type, the line-level constants and a parity
// helper. The transmitter imports it; the receiver uses the same line levels.
package uart_pkg;

  // Transmitter frame sequencer states. Codes 5..7 are unused and are treated
  // as illegal by the FSM, which recovers to IDLE.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_t;

  // Line levels: the line idles (and stops) high; a start bit pulls it low.
  localparam logic UART_IDLE_LVL  = 1'b1;
  localparam logic UART_START_LVL = 1'b0;

  // Widest supported data field; narrower frames zero-extend to this width.
  localparam int unsigned UART_MAX_DATA_BITS = 8;

  // Parity bit for a zero-extended data word. Even parity is the XOR of all
  // data bits; odd parity is its inverse. Zero padding does not affect it.
  function automatic logic uart_parity(input logic [UART_MAX_DATA_BITS-1:0] data,
                                       input logic                          odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_transmitter.sv
// UART transmitter.
// Serialises one word per frame: start bit, DATA_BITS data bits LSB first, an
// optional parity bit, then STOP_BITS stop bits. Bit timing comes entirely from
// the external baud_tick strobe. A one-entry holding register sits in front of
// the shift register so a following word can be accepted while a frame is on
// the line, giving back-to-back frames with no idle bit between them.
//
// Ports:
//   clk        system clock
//   rst        asynchronous active-low reset
//   baud_tick  one-clk strobe per bit period; FSM only moves on these edges
//   tx_valid   producer offers tx_data
//   tx_data    word to send (DATA_BITS wide)
//   tx_ready   holding register empty; word taken on tx_valid & tx_ready
//   tx_serial  registered serial line, idle high
//   tx_busy    FSM is not in IDLE
//   tx_done    one-clk pulse at the end of the last stop bit
module uart_transmitter
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS  = 8,  // 5..8
  parameter int unsigned PARITY_EN  = 0,  // 1 = parity bit after the data
  parameter int unsigned PARITY_ODD = 0,  // 1 = odd, 0 = even
  parameter int unsigned STOP_BITS  = 1   // 1 or 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 baud_tick,
  input  logic                 tx_valid,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx_ready,
  output logic                 tx_serial,
  output logic                 tx_busy,
  output logic                 tx_done
);

  localparam int unsigned IDX_W = $clog2(DATA_BITS);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DATA_BITS - 1);
  localparam logic             LAST_STOP = 1'(STOP_BITS - 1);
  localparam logic             USE_PARITY = (PARITY_EN != 0);
  localparam logic             ODD_PARITY = (PARITY_ODD != 0);

  // Sequencer state.
  tx_state_t            state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [IDX_W-1:0]     bit_idx_q, bit_idx_d;
  logic                 stop_cnt_q, stop_cnt_d;
  logic                 parity_q, parity_d;
  logic                 tx_serial_q, tx_serial_d;
  logic                 tx_done_q, tx_done_d;

  // Holding register.
  logic [DATA_BITS-1:0] hold_q, hold_d;
  logic                 hold_full_q, hold_full_d;

  logic                          accept;
  logic                          consume;
  logic [UART_MAX_DATA_BITS-1:0] hold_ext;

  assign accept = tx_valid & ~hold_full_q;

  // Zero-extend the held word so the parity helper sees a fixed width.
  always_comb begin
    hold_ext                = '0;
    hold_ext[DATA_BITS-1:0] = hold_q;
  end

  // ---------------------------------------------------------------------------
  // Frame sequencer: next state and line value
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    bit_idx_d   = bit_idx_q;
    stop_cnt_d  = stop_cnt_q;
    parity_d    = parity_q;
    tx_serial_d = tx_serial_q;
    tx_done_d   = 1'b0;
    consume     = 1'b0;

    case (state_q)
      IDLE: begin
        if (baud_tick && hold_full_q) begin
          state_d     = START;
          tx_serial_d = UART_START_LVL;
          consume     = 1'b1;
        end
      end

      START: begin
        if (baud_tick) begin
          state_d     = DATA;
          tx_serial_d = shift_q[0];
          bit_idx_d   = '0;
        end
      end

      DATA: begin
        if (baud_tick) begin
          if (bit_idx_q == LAST_IDX) begin
            if (USE_PARITY) begin
              state_d     = PARITY;
              tx_serial_d = parity_q;
            end else begin
              state_d     = STOP;
              tx_serial_d = UART_IDLE_LVL;
              stop_cnt_d  = 1'b0;
            end
          end else begin
            // shift_q[0] is on the line now; bit 1 becomes the next bit out.
            shift_d     = shift_q >> 1;
            tx_serial_d = shift_q[1];
            bit_idx_d   = bit_idx_q + 1'b1;
          end
        end
      end

      PARITY: begin
        if (baud_tick) begin
          state_d     = STOP;
          tx_serial_d = UART_IDLE_LVL;
          stop_cnt_d  = 1'b0;
        end
      end

      STOP: begin
        if (baud_tick) begin
          if (stop_cnt_q == LAST_STOP) begin
            tx_done_d = 1'b1;
            if (hold_full_q) begin
              // Next word is waiting: go straight to its start bit.
              state_d     = START;
              tx_serial_d = UART_START_LVL;
              consume     = 1'b1;
            end else begin
              state_d     = IDLE;
              tx_serial_d = UART_IDLE_LVL;
            end
          end else begin
            stop_cnt_d = stop_cnt_q + 1'b1;
          end
        end
      end

      default: begin
        // Unused encodings recover immediately, tick or not.
        state_d     = IDLE;
        tx_serial_d = UART_IDLE_LVL;
      end
    endcase

    // Moving the held word into the shift register also fixes its parity.
    if (consume) begin
      shift_d  = hold_q;
      parity_d = uart_parity(hold_ext, ODD_PARITY);
    end
  end

  // ---------------------------------------------------------------------------
  // Holding register: accept and consume never coincide because accept needs
  // the register empty and consume needs it full.
  // ---------------------------------------------------------------------------
  always_comb begin
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    if (consume) begin
      hold_full_d = 1'b0;
    end else if (accept) begin
      hold_d      = tx_data;
      hold_full_d = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      shift_q     <= '0;
      bit_idx_q   <= '0;
      stop_cnt_q  <= 1'b0;
      parity_q    <= 1'b0;
      tx_serial_q <= UART_IDLE_LVL;
      tx_done_q   <= 1'b0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      bit_idx_q   <= bit_idx_d;
      stop_cnt_q  <= stop_cnt_d;
      parity_q    <= parity_d;
      tx_serial_q <= tx_serial_d;
      tx_done_q   <= tx_done_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign tx_ready  = ~hold_full_q;
  assign tx_serial = tx_serial_q;
  assign tx_busy   = (state_q != IDLE);
  assign tx_done   = tx_done_q;

endmodule

// File: tb/tb_uart_transmitter.sv
// Bench for uart_transmitter. Four instances cover 8N1, 8E1, 8O1 and 8N2 and
// share clock, reset and baud_tick. Stimulus pushes the hand-computed frame
// (bit i = line level in bit period i) into a queue; a monitor decodes each
// line at every tick edge and pops/compares when a frame's last stop ends.
module tb_uart_transmitter;

  localparam int NI = 4;
  localparam int FLEN [NI] = '{10, 11, 11, 11};

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic baud_tick = 1'b0;
  logic tick_en = 1'b1;
  int   tick_div = 0;

  logic [NI-1:0] tx_valid;
  logic [NI-1:0] tx_ready;
  logic [NI-1:0] tx_serial;
  logic [NI-1:0] tx_busy;
  logic [NI-1:0] tx_done;
  logic [7:0]    tx_data [NI];

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          inst;
    logic [11:0] bits;
  } exp_t;
  exp_t exp_q[$];

  int          cnt      [NI];
  logic [11:0] got      [NI];
  logic        last_ser [NI];
  int          done_cnt [NI];

  uart_transmitter u_8n1 (
    .clk(clk), .rst(rst), .baud_tick(baud_tick), .tx_valid(tx_valid[0]),
    .tx_data(tx_data[0]), .tx_ready(tx_ready[0]), .tx_serial(tx_serial[0]),
    .tx_busy(tx_busy[0]), .tx_done(tx_done[0])
  );
  uart_transmitter #(.PARITY_EN(1), .PARITY_ODD(0)) u_8e1 (
    .clk(clk), .rst(rst), .baud_tick(baud_tick), .tx_valid(tx_valid[1]),
    .tx_data(tx_data[1]), .tx_ready(tx_ready[1]), .tx_serial(tx_serial[1]),
    .tx_busy(tx_busy[1]), .tx_done(tx_done[1])
  );
  uart_transmitter #(.PARITY_EN(1), .PARITY_ODD(1)) u_8o1 (
    .clk(clk), .rst(rst), .baud_tick(baud_tick), .tx_valid(tx_valid[2]),
    .tx_data(tx_data[2]), .tx_ready(tx_ready[2]), .tx_serial(tx_serial[2]),
    .tx_busy(tx_busy[2]), .tx_done(tx_done[2])
  );
  uart_transmitter #(.STOP_BITS(2)) u_8n2 (
    .clk(clk), .rst(rst), .baud_tick(baud_tick), .tx_valid(tx_valid[3]),
    .tx_data(tx_data[3]), .tx_ready(tx_ready[3]), .tx_serial(tx_serial[3]),
    .tx_busy(tx_busy[3]), .tx_done(tx_done[3])
  );

  always #5 clk = ~clk;

  // One tick every 16 clks, changed on negedges so it is stable at posedge.
  always @(negedge clk) begin
    baud_tick = tick_en && (tick_div == 15);
    tick_div  = (tick_div + 1) % 16;
  end

  task automatic check(input string name, input int inst, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s inst%0d: got %b expected %b at %0t", name, inst, act, exp, $time);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: decodes every line at tick edges, checks done/busy/stability.
  always @(posedge clk) begin
    exp_t e;
    logic ed;
    #1;
    for (int i = 0; i < NI; i++) begin
      if (!rst) begin
        cnt[i]      = 0;
        last_ser[i] = 1'b1;
      end else if (baud_tick) begin
        ed = (cnt[i] == FLEN[i]);
        check("done_at_tick", i, tx_done[i], ed);
        if (ed) begin
          done_cnt[i]++;
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL frame inst%0d: got %h expected none", i, got[i]);
          end else begin
            e = exp_q.pop_front();
            if (e.inst != i || e.bits != got[i]) begin
              errors++;
              $display("FAIL frame inst%0d: got %h expected inst%0d %h", i, got[i], e.inst,
                       e.bits);
            end
          end
          cnt[i] = 0;
        end
        if (cnt[i] == 0) begin
          if (tx_serial[i] == 1'b0) begin
            got[i] = '0;
            cnt[i] = 1;
          end
        end else begin
          got[i][cnt[i]] = tx_serial[i];
          cnt[i]++;
        end
        check("busy_at_tick", i, tx_busy[i], cnt[i] != 0);
        last_ser[i] = tx_serial[i];
      end else begin
        check("done_no_tick", i, tx_done[i], 1'b0);
        check("line_hold", i, tx_serial[i], last_ser[i]);
      end
    end
  end

  // Offer a word; optionally register its expected frame with the scoreboard.
  task automatic send(input int i, input logic [7:0] d, input logic [11:0] frame,
                      input logic expect_frame);
    int guard = 0;
    if (expect_frame) exp_q.push_back('{inst: i, bits: frame});
    @(negedge clk);
    tx_data[i]  = d;
    tx_valid[i] = 1'b1;
    while (!tx_ready[i] && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 1000) begin
      check("ready_timeout", i, 1'b1, 1'b0);
    end
    @(posedge clk);
    #1;
    tx_valid[i] = 1'b0;
    check("ready_low_when_full", i, tx_ready[i], 1'b0);
  endtask

  task automatic wait_drain();
    int guard = 0;
    while (exp_q.size() != 0 && guard < 5000) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 5000) check_int("drain_timeout", exp_q.size(), 0);
    repeat (20) @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    errors++;
    $display("FAIL watchdog: simulation did not complete");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    int   n;
    int   guard;
    logic s_ser, s_busy, s_rdy;
    tx_valid = '0;
    for (int i = 0; i < NI; i++) begin
      tx_data[i]  = 8'h00;
      done_cnt[i] = 0;
      cnt[i]      = 0;
      last_ser[i] = 1'b1;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      check("rst_serial", i, tx_serial[i], 1'b1);
      check("rst_busy", i, tx_busy[i], 1'b0);
      check("rst_done", i, tx_done[i], 1'b0);
      check("rst_ready", i, tx_ready[i], 1'b1);
    end
    rst = 1'b1;
    repeat (5) @(negedge clk);

    // 8N1 0xA5: periods 0,1,0,1,0,0,1,0,1,1; done 160 clks after START entry.
    send(0, 8'hA5, 12'h34A, 1'b1);
    guard = 0;
    while (!tx_busy[0] && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    n = 0;
    while (!tx_done[0] && n < 400) begin
      @(negedge clk);
      n++;
    end
    check_int("busy_to_done_clks", n, 160);
    wait_drain();

    // Parity: 8E1 0xA5 -> 0; 8O1 0x01 -> 0; 8O1 0x00 -> 1.
    send(1, 8'hA5, 12'h54A, 1'b1);
    wait_drain();
    send(2, 8'h01, 12'h402, 1'b1);
    wait_drain();
    send(2, 8'h00, 12'h600, 1'b1);
    wait_drain();

    // Back-to-back 0x55, 0xAA: busy must stay high across both frames.
    send(0, 8'h55, 12'h2AA, 1'b1);
    send(0, 8'hAA, 12'h354, 1'b1);
    guard = 0;
    while (exp_q.size() != 0 && guard < 5000) begin
      @(negedge clk);
      if (exp_q.size() != 0) check("b2b_busy", 0, tx_busy[0], 1'b1);
      guard++;
    end
    wait_drain();

    // 8N2 0xFF: two stop periods before done.
    send(3, 8'hFF, 12'h7FE, 1'b1);
    wait_drain();

    // Tick stalled for 100 clks in the middle of the data bits.
    send(0, 8'h5A, 12'h2B4, 1'b1);
    guard = 0;
    while (cnt[0] != 3 && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    check_int("pause_reach_data", cnt[0], 3);
    @(posedge clk);
    #2;
    tick_en = 1'b0;
    s_ser  = tx_serial[0];
    s_busy = tx_busy[0];
    s_rdy  = tx_ready[0];
    repeat (100) @(negedge clk);
    check("pause_serial", 0, tx_serial[0], s_ser);
    check("pause_busy", 0, tx_busy[0], s_busy);
    check("pause_ready", 0, tx_ready[0], s_rdy);
    #2;
    tick_en = 1'b1;
    wait_drain();

    // Reset during data bit 3 of 0x3C; the aborted frame is never expected.
    send(0, 8'h3C, 12'h000, 1'b0);
    guard = 0;
    while (cnt[0] != 5 && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    check_int("rst_reach_bit3", cnt[0], 5);
    #2;
    rst = 1'b0;
    #1;
    check("async_rst_serial", 0, tx_serial[0], 1'b1);
    check("async_rst_busy", 0, tx_busy[0], 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("post_rst_ready", 0, tx_ready[0], 1'b1);
    check("post_rst_serial", 0, tx_serial[0], 1'b1);
    send(0, 8'h81, 12'h302, 1'b1);
    wait_drain();

    check_int("done_count_8n1", done_cnt[0], 5);
    check_int("done_count_8e1", done_cnt[1], 1);
    check_int("done_count_8o1", done_cnt[2], 2);
    check_int("done_count_8n2", done_cnt[3], 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
